// File: rtl/pico_isa_pkg.sv
// picoRISC ISA constants shared by fetch/decode and the mapper.
// Opcodes, one-hot bit order, IR field positions, fetch states.
package pico_isa_pkg;

  localparam logic [7:0] OP_INTD      = 8'h00;
  localparam logic [7:0] OP_INTE      = 8'h01;
  localparam logic [7:0] OP_LOAD      = 8'h02;
  localparam logic [7:0] OP_STORE     = 8'h03;
  localparam logic [7:0] OP_ADD       = 8'h04;
  localparam logic [7:0] OP_SUB       = 8'h05;
  localparam logic [7:0] OP_REALMUL   = 8'h06;
  localparam logic [7:0] OP_REALCLAMP = 8'h07;
  localparam logic [7:0] OP_INTREAL   = 8'h08;
  localparam logic [7:0] OP_INC       = 8'h09;
  localparam logic [7:0] OP_DEC       = 8'h0A;
  localparam logic [7:0] OP_AND       = 8'h0B;
  localparam logic [7:0] OP_OR        = 8'h0C;
  localparam logic [7:0] OP_XOR       = 8'h0D;
  localparam logic [7:0] OP_ASR       = 8'h0E;
  localparam logic [7:0] OP_ASL       = 8'h0F;
  localparam logic [7:0] OP_CALL      = 8'h10;
  localparam logic [7:0] OP_RET       = 8'h11;
  localparam logic [7:0] N_OPS        = 8'h12;

  // Mapper input order equals opcode value
  localparam int SIG_INTD      = 0;
  localparam int SIG_INTE      = 1;
  localparam int SIG_LOAD      = 2;
  localparam int SIG_STORE     = 3;
  localparam int SIG_ADD       = 4;
  localparam int SIG_SUB       = 5;
  localparam int SIG_REALMUL   = 6;
  localparam int SIG_REALCLAMP = 7;
  localparam int SIG_INTREAL   = 8;
  localparam int SIG_INC       = 9;
  localparam int SIG_DEC       = 10;
  localparam int SIG_AND       = 11;
  localparam int SIG_OR        = 12;
  localparam int SIG_XOR       = 13;
  localparam int SIG_ASR       = 14;
  localparam int SIG_ASL       = 15;
  localparam int SIG_CALL      = 16;
  localparam int SIG_RET       = 17;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RS_HI  = 19;
  localparam int RS_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_DECODE = 2'd2,
    ST_VALID  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] signals;
    logic        illegal;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
  } dec_t;

endpackage

// File: rtl/pico_opcode_onehot.sv
// Combinational opcode -> one-hot operation vector decoder.
// Opcodes past the defined set flag illegal with an all-zero vector.
module pico_opcode_onehot
  import pico_isa_pkg::*;
(
  input  logic [7:0]  opcode,
  output logic [31:0] signals,
  output logic        illegal
);

  always_comb begin
    signals = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (opcode < N_OPS): signals[opcode[4:0]] = 1'b1;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pico_ir_fetch_decode.sv
// picoRISC instruction fetch, IR latch and opcode decode stage.
// Owns the PC; holds the decoded word until the sequencer acks.
module pico_ir_fetch_decode
  import pico_isa_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              dec_valid,
  input  logic              dec_ack,
  output logic [31:0]       signals,
  output logic              illegal,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in
);

  fetch_state_e      state, state_nx;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  dec_t              dec_q, dec_d;
  logic              fetch_done;

  assign fetch_done = (state == ST_REQ) && mem_ack;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (start)   state_nx = ST_REQ;
      ST_REQ:    if (mem_ack) state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_VALID;
      ST_VALID:  if (dec_ack) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  pico_opcode_onehot u_onehot (
    .opcode  (ir_q[OPC_HI:OPC_LO]),
    .signals (dec_d.signals),
    .illegal (dec_d.illegal)
  );

  assign dec_d.rd  = ir_q[RD_HI:RD_LO];
  assign dec_d.rs  = ir_q[RS_HI:RS_LO];
  assign dec_d.imm = ir_q[IMM_HI:IMM_LO];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      dec_q <= '0;
    end else begin
      state <= state_nx;
      // a reload wins over the post-fetch increment
      if (pc_load)
        pc_q <= pc_in;
      else if (fetch_done)
        pc_q <= pc_q + ADDR_W'(1);
      if (fetch_done)
        ir_q <= mem_rdata;
      if (state == ST_DECODE)
        dec_q <= dec_d;
    end
  end

  assign mem_req   = (state == ST_REQ);
  assign mem_addr  = pc_q;
  assign dec_valid = (state == ST_VALID);
  assign signals   = dec_q.signals;
  assign illegal   = dec_q.illegal;
  assign rd        = dec_q.rd;
  assign rs        = dec_q.rs;
  assign imm       = dec_q.imm;
  assign ir        = ir_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_pico_ir_fetch_decode.sv
// Scoreboard bench for pico_ir_fetch_decode.
// Random fetches checked against an ISA-level reference model.
module tb_pico_ir_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        dec_valid;
  logic        dec_ack;
  logic [31:0] signals;
  logic        illegal;
  logic [31:0] ir;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        pc_load;
  logic [15:0] pc_in;

  pico_ir_fetch_decode #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .RESET_PC (16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dec_valid (dec_valid),
    .dec_ack   (dec_ack),
    .signals   (signals),
    .illegal   (illegal),
    .ir        (ir),
    .rd        (rd),
    .rs        (rs),
    .imm       (imm),
    .pc        (pc),
    .pc_load   (pc_load),
    .pc_in     (pc_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] sig;
    logic        ill;
    logic [15:0] pc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mpc;
  bit          done = 0;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endfunction

  function automatic exp_t model(logic [31:0] w, logic [15:0] p);
    exp_t e;
    int   op;
    op    = int'(w[31:24]);
    e.word = w;
    e.pc   = p;
    e.ill  = (op >= 18);
    e.sig  = (op < 18) ? (32'd1 << op) : 32'd0;
    return e;
  endfunction

  // monitor: compare on each rising dec_valid
  initial begin : monitor
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (dec_valid && !prev) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("ir", ir, e.word);
          chk("signals", signals, e.sig);
          chk("illegal", illegal, e.ill);
          chk("rd", rd, e.word[23:20]);
          chk("rs", rs, e.word[19:16]);
          chk("imm", imm, e.word[15:0]);
          chk("pc", pc, e.pc);
        end
      end
      if (dec_valid) chk("req_in_valid", mem_req, 0);
      prev = dec_valid;
    end
  end

  task automatic do_fetch(input logic [31:0] w, input int wt,
                          input bit ld, input logic [15:0] ldv,
                          input int hold);
    logic [31:0] s_ir, s_sig;
    logic        s_ill;
    logic [15:0] s_pc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, mpc);
    repeat (wt) begin
      @(negedge clk);
      chk("req_held", mem_req, 1);
    end
    mem_rdata = w;
    mem_ack   = 1'b1;
    pc_load   = ld;
    pc_in     = ldv;
    mpc       = ld ? ldv : mpc + 16'd1;
    sbq.push_back(model(w, mpc));
    @(negedge clk);
    mem_ack   = 1'b0;
    pc_load   = 1'b0;
    mem_rdata = $urandom;
    for (int i = 0; i < 5 && !dec_valid; i++) @(negedge clk);
    if (!dec_valid) chk("valid_timeout", 0, 1);
    s_ir  = ir;
    s_sig = signals;
    s_ill = illegal;
    s_pc  = pc;
    repeat (hold) begin
      start   = 1'($urandom);
      mem_ack = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", dec_valid, 1);
      chk("hold_ir", ir, s_ir);
      chk("hold_sig", signals, s_sig);
      chk("hold_ill", illegal, s_ill);
      chk("hold_pc", pc, s_pc);
    end
    dec_ack = 1'b1;
    start   = 1'($urandom);
    @(negedge clk);
    dec_ack = 1'b0;
    start   = 1'b0;
    mem_ack = 1'b0;
    chk("valid_drop", dec_valid, 0);
    chk("idle_no_req", mem_req, 0);
  endtask

  task automatic load_pc(input logic [15:0] v);
    @(negedge clk);
    pc_load = 1'b1;
    pc_in   = v;
    @(negedge clk);
    pc_load = 1'b0;
    mpc     = v;
    chk("pc_loaded", pc, v);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] w;
    rst_n = 1'b0; start = 0; mem_ack = 0; mem_rdata = '0;
    dec_ack = 0; pc_load = 0; pc_in = '0;
    mpc = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 0);
    chk("rst_sig", signals, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_valid", dec_valid, 0);
    rst_n = 1'b1;

    do_fetch(32'h04120005, 2, 0, 16'h0, 1);
    do_fetch(32'h11000000, 0, 0, 16'h0, 0);
    do_fetch(32'h10000000, 1, 0, 16'h0, 0);
    do_fetch(32'h12345678, 0, 0, 16'h0, 0);
    do_fetch(32'hFF000001, 0, 0, 16'h0, 0);
    do_fetch(32'h0B000000, 0, 0, 16'h0, 0);
    load_pc(16'hFFFF);
    do_fetch(32'h09000000, 0, 0, 16'h0, 0);
    do_fetch(32'h0A00BEEF, 1, 1, 16'h0040, 0);
    do_fetch(32'h05ABCDEF, 0, 0, 16'h0, 10);

    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0)
        w[31:24] = 8'($urandom_range(0, 19));
      do_fetch(w, $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0),
               16'($urandom), $urandom_range(0, 3));
    end

    // reset in the middle of a fetch
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mr_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("mr_req_drop", mem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc   = 16'h0000;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h04000000;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mr_valid", dec_valid, 0);
      chk("mr_req", mem_req, 0);
      chk("mr_ir", ir, 0);
      chk("mr_pc", pc, mpc);
    end
    chk("sb_empty", sbq.size(), 0);
    done = 1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pico_ir_fetch_decode.md
Name: pico_ir_fetch_decode

Overview:
- Fetches instruction words for the picoRISC CPU from memory over a req/ack handshake and latches them into the instruction register (IR).
- Decodes the IR opcode into the 32-bit one-hot operation vector consumed by the microprogram branch-address mapper.
- Holds the decoded vector stable until the microprogram sequencer acknowledges it.
- Owns the program counter (PC); supports PC reload for call/ret/jumps.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- DATA_W, 32, instruction word width.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin next fetch (sequencer ready for new instruction)
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address (= PC)
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- mem_ack  in  1  read complete, single-cycle pulse
- dec_valid  out  1  signals/ir/fields valid
- dec_ack  in  1  sequencer consumed the decoded instruction
- signals  out  32  one-hot operation vector
- illegal  out  1  opcode outside the defined set
- ir  out  DATA_W  latched instruction word
- rd  out  4  IR[23:20]
- rs  out  4  IR[19:16]
- imm  out  16  IR[15:0]
- pc  out  ADDR_W  current PC
- pc_load  in  1  load PC from pc_in
- pc_in  in  ADDR_W  new PC value

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, signals=0, illegal=0, dec_valid=0, mem_req=0, mem_addr=RESET_PC.
- States:
  - IDLE: start=1 -> REQ.
  - REQ: mem_req=1, mem_addr=pc, held until mem_ack.
  - On mem_ack in REQ: ir<=mem_rdata, pc<=pc+1 (wraps modulo 2^ADDR_W), -> DECODE. mem_ack is combinationally accepted in the first REQ cycle; minimum fetch latency is 1 cycle.
  - DECODE, one cycle: signals, illegal and fields registered from ir -> VALID.
  - VALID: dec_valid=1; all outputs frozen. dec_ack=1 -> IDLE, dec_valid drops next cycle.
- Latency: start to dec_valid is at least 3 cycles (REQ, DECODE, then VALID), plus memory wait.
- Opcode = IR[31:24]. Values 0x00..0x11 set signals[opcode] in this order:
  - 0x00 intd, 0x01 inte, 0x02 load, 0x03 store, 0x04 add, 0x05 sub
  - 0x06 realmul, 0x07 realclamp, 0x08 intreal, 0x09 inc, 0x0A dec
  - 0x0B and, 0x0C or, 0x0D xor, 0x0E asr, 0x0F asl, 0x10 call, 0x11 ret
  - signals[31:18] are always 0.
- Opcode >= 0x12: signals=0, illegal=1. The instruction still presents as dec_valid so the sequencer can trap.
- At most one bit of signals is ever set.
- pc_load has priority over the fetch increment in every state. If it coincides with mem_ack, pc<=pc_in and ir still latches mem_rdata.
- mem_req must not drop before mem_ack. mem_ack outside REQ is ignored.
- start outside IDLE is ignored. dec_ack outside VALID is ignored.
- start and dec_ack together in VALID: return to IDLE only. start must be re-asserted.
- Reset mid-fetch: mem_req drops immediately (async). A late mem_ack after reset is ignored.

Decomposition:
- Shared package pico_isa_pkg:
  - opcode localparams OP_INTD..OP_RET (0x00..0x11)
  - signal bit-index localparams (matching the mapper's input order)
  - field bit positions
  - fetch FSM state encoding
- One sub-module is natural: pico_opcode_onehot, a combinational opcode -> {signals, illegal} decoder, reusable by the assembler-check bench.

Test Plan:
1. Reset with RESET_PC=0x0000, start=1, memory returns 0x04120005 after 2 wait cycles -> mem_addr=0x0000; dec_valid rises; signals=32'h0000_0010 (add); rd=1, rs=2, imm=0x0005; pc=0x0001; illegal=0.
2. Fetch 0x11000000 then 0x10000000 -> signals=32'h0002_0000 (ret), then 32'h0001_0000 (call); PC increments 0->1->2.
3. Fetch opcode 0x12, then 0xFF -> signals=0, illegal=1, dec_valid=1 both times; next legal fetch clears illegal.
4. pc=0xFFFF, fetch -> pc wraps to 0x0000. pc_load=1 with pc_in=0x0040 in the same cycle as mem_ack -> pc=0x0040, ir=fetched word.
5. Hold dec_ack=0 for 10 cycles in VALID, toggling mem_ack and start -> outputs unchanged, mem_req=0. Then dec_ack=1 -> dec_valid=0 next cycle, state IDLE.
6. Assert rst_n=0 while mem_req=1, then pulse mem_ack after release -> mem_req=0 immediately, ir stays 0, no dec_valid.
